// File: rtl/bc_pkg.sv
// Shared defaults and FSM encoding for the result deserializer.
package bc_pkg;
  localparam int NBITS_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/bc_out_buf.sv
// One-entry valid/ready output register; a full buffer still accepts when drained the same cycle.
module bc_out_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/bc_result_deser.sv
// Collects the LSB-first serial sum plus final carry into a parallel result word.
module bc_result_deser
  import bc_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             bit_in,
  input  logic             co_in,
  output logic [NBITS:0]   res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err_ovf,
  output logic             err_restart,
  input  logic             err_clr
);
  localparam int CW = $clog2(NBITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [NBITS-1:0] sr, sr_ins;
  logic             done, restart, buf_ready;

  // Positions above cnt are always zero, so OR-ing in the new bit places it.
  assign sr_ins = sr | (NBITS'(bit_in) << cnt);
  assign busy   = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = SHIFT;
        cnt_nxt   = CW'(1);
      end
      SHIFT: if (start) begin
        restart = 1'b1;
        cnt_nxt = CW'(1);
      end else if (cnt == LAST) begin
        done      = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      err_ovf     <= 1'b0;
      err_restart <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start)               sr <= NBITS'(bit_in);
      else if (done)           sr <= '0;
      else if (state == SHIFT) sr <= sr_ins;
      // A fresh error in the clear cycle keeps the flag set.
      err_ovf     <= (done & ~buf_ready) | (err_ovf & ~err_clr);
      err_restart <= restart | (err_restart & ~err_clr);
    end
  end

  bc_out_buf #(.W(NBITS + 1)) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (done),
    .in_data   ({co_in, sr_ins}),
    .in_ready  (buf_ready),
    .out_valid (res_valid),
    .out_data  (res_data),
    .out_ready (res_ready)
  );
endmodule

// File: doc/bc_result_deser.md
BC_RESULT_DESER -- requirements
Module: bc_result_deser

Interface
REQ-001 The block SHALL have parameter NBITS, default 16, giving the serial frame length in bits (LSB first); legal range 2..32.
REQ-002 The block SHALL have the port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have the port rstn  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have the port start  input  1  marks the cycle carrying bit 0 of a frame.
REQ-005 The block SHALL have the port bit_in  input  1  registered serial sum bit from the final bit-block stage.
REQ-006 The block SHALL have the port co_in  input  1  final-stage carry; sampled only on bit NBITS-1.
REQ-007 The block SHALL have the port res_data  output  NBITS+1  assembled result {carry, bits[NBITS-1:0]}.
REQ-008 The block SHALL have the port res_valid  output  1  res_data holds an unconsumed result.
REQ-009 The block SHALL have the port res_ready  input  1  consumer accepts res_data when res_valid and res_ready are both high.
REQ-010 The block SHALL have the port busy  output  1  a frame is being shifted in.
REQ-011 The block SHALL have the port err_ovf  output  1  sticky: a completed frame was dropped because the buffer was full.
REQ-012 The block SHALL have the port err_restart  output  1  sticky: start arrived mid-frame.
REQ-013 The block SHALL have the port err_clr  input  1  single-cycle pulse that clears both sticky flags.

Function
REQ-014 The FSM SHALL have two states, IDLE and SHIFT.
REQ-015 IDLE->SHIFT SHALL occur on start=1: capture bit_in into shift position 0 and set cnt=1.
REQ-016 In SHIFT, each cycle SHALL capture bit_in into position cnt and increment cnt; no valid-gap input exists, so every SHIFT cycle is a data bit.
REQ-017 When cnt=NBITS-1, the block SHALL capture bit_in and co_in, complete the frame, and go to IDLE, or to SHIFT with cnt=1 if start=1 in the next cycle (back-to-back frames).
REQ-018 A completed frame SHALL load the one-entry output buffer on the following clock edge; res_valid rises that edge, giving latency NBITS cycles from the start cycle to res_valid.
REQ-019 The buffer SHALL hold res_data stable while res_valid=1 and res_ready=0.
REQ-020 On handshake without a new completion, res_valid SHALL fall next edge.
REQ-021 If a handshake and a completion occur in the same cycle, the buffer SHALL load the new word and res_valid SHALL stay 1 with no bubble.
REQ-022 If a completion occurs while the buffer is full and res_ready=0, the new word SHALL be discarded, the buffer kept intact, and err_ovf set.
REQ-023 start in SHIFT with cnt<NBITS SHALL abort the partial frame (no output), set err_restart, and restart at cnt=1 with the current bit_in as bit 0.
REQ-024 busy SHALL be 1 exactly while in SHIFT.
REQ-025 If err_clr and a new error condition coincide, the error SHALL win and the flag SHALL remain set.
REQ-026 cnt width SHALL be clog2(NBITS)+1; cnt SHALL never exceed NBITS-1.

Reset
REQ-027 rstn=0 at a clock edge SHALL force IDLE, cnt=0, shift register 0, res_data 0, res_valid 0, busy 0, err_ovf 0, err_restart 0.
REQ-028 Reset mid-frame SHALL discard the partial frame without any output or error flag.
REQ-029 start sampled on the first edge after rstn returns high SHALL be honoured.

Structure
REQ-030 Package bc_pkg SHALL hold the NBITS default and the state encoding (IDLE=0, SHIFT=1).
REQ-031 The output buffer SHALL be the sub-module bc_out_buf (one-entry valid/ready register, width parameter); the shift register, counter and FSM SHALL stay in the top module.

Verification
REQ-032 The bench SHALL check a single frame: NBITS=16, start at t0, bits of 0xA5C3 LSB first, co_in=1 on the last bit -> res_valid at t0+16, res_data=0x1A5C3.
REQ-033 The bench SHALL check back-to-back frames: 0x0001 then 0xFFFF (co=0) with res_ready=1 -> two results on consecutive frame boundaries, no gap, no errors.
REQ-034 The bench SHALL check backpressure: res_ready=0, three frames -> first result held, the later two dropped, err_ovf=1; err_clr -> err_ovf=0.
REQ-035 The bench SHALL check a simultaneous handshake and completion: res_ready pulsed on the completion-load edge -> res_valid continuous, second word visible the next cycle.
REQ-036 The bench SHALL check restart: start at bit 7 of a frame -> err_restart=1, next result equals the 16 bits following the second start.
REQ-037 The bench SHALL check mid-frame reset: rstn=0 at bit 9 -> all outputs 0, no res_valid; a fresh frame afterwards completes correctly.
